// File: rtl/pdp_med_pkg.sv
// Shared definitions for the PDP median pooling blocks: data widths,
// sequencer state encoding and the precision encoding used by the med1d core.
package pdp_med_pkg;

   localparam int DATA_W = 22;
   localparam int KW_W   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } med_state_e;

   typedef enum logic [1:0] {
      PREC_INT8  = 2'd0,
      PREC_INT16 = 2'd1,
      PREC_FP16  = 2'd2,
      PREC_NONE  = 2'd3
   } med_prec_e;

   // Collapse the one-hot register enables into a single precision code.
   function automatic med_prec_e prec_decode(input logic int8_en,
                                             input logic int16_en,
                                             input logic fp16_en);
      med_prec_e prec;
      prec = PREC_NONE;
      if (int8_en)
         prec = PREC_INT8;
      else if (int16_en)
         prec = PREC_INT16;
      else if (fp16_en)
         prec = PREC_FP16;
      return prec;
   endfunction

endpackage

// File: rtl/pdp_med1d_window_seq.sv
// Window-aware sequencer and accumulator wrapped around the med1d core.
// Streams pixels into the core as data0, feeds the running median back as
// data1, and emits one median per kernel window on a registered valid/ready
// output that can be back-pressured.
module pdp_med1d_window_seq
   import pdp_med_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [KW_W-1:0]   reg2dp_kernel_width,
   input  logic              reg2dp_int8_en,
   input  logic              reg2dp_int16_en,
   input  logic              reg2dp_fp16_en,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_dat,
   input  logic              in_last,
   output logic              core_enable,
   output logic [DATA_W-1:0] core_data0,
   output logic [DATA_W-1:0] core_data1,
   output logic              core_int8_en,
   output logic              core_int16_en,
   output logic              core_fp16_en,
   input  logic [DATA_W-1:0] core_median,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_dat
);

   med_state_e        state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] out_dat_q, out_dat_d;
   logic [KW_W-1:0]   cnt_q, cnt_d;
   logic [KW_W-1:0]   kw_q, kw_d;
   logic              out_vld_q, out_vld_d;

   logic              accept;
   logic              out_stall;
   logic              win_full;
   logic              complete;

   // Handshake qualifiers: a pending result that is not being taken, and
   // whether the current pixel would be the last one the window can hold.
   always_comb begin
      out_stall = out_vld_q && !out_rdy;
      win_full  = (cnt_q == kw_q);
   end

   // Input ready. IDLE may only open a new window once the output slot is
   // free or draining. ACC normally always accepts, but refuses a closing
   // pixel (full window or early in_last) while a result is still stuck, so
   // a completion can never overwrite an unread median.
   always_comb begin
      in_rdy = 1'b0;
      if (!rst) begin
         if (state_q == IDLE)
            in_rdy = !out_stall;
         else
            in_rdy = !((win_full || in_last) && out_stall);
      end
   end

   // Core interface: the core only toggles on real transfers, and the first
   // pixel of a window is paired with itself so its median is the pixel.
   always_comb begin
      accept        = in_vld && in_rdy;
      core_enable   = accept;
      core_data0    = in_dat;
      core_data1    = (state_q == IDLE) ? in_dat : acc_q;
      core_int8_en  = reg2dp_int8_en;
      core_int16_en = reg2dp_int16_en;
      core_fp16_en  = reg2dp_fp16_en;
   end

   // Window sequencing: latch the kernel width at window start, accumulate
   // the core median per accepted pixel and detect window completion.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      kw_d     = kw_q;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               kw_d  = reg2dp_kernel_width;
               acc_d = core_median;
               if ((reg2dp_kernel_width == '0) || in_last) begin
                  complete = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d   = KW_W'(1);
                  state_d = ACC;
               end
            end
         end
         ACC: begin
            if (accept) begin
               acc_d = core_median;
               if (win_full || in_last) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + KW_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output slot: hold until taken, and reload without a bubble when a
   // window completes in the same cycle the previous result is accepted.
   always_comb begin
      out_vld_d = out_vld_q && !out_rdy;
      out_dat_d = out_dat_q;
      if (complete) begin
         out_vld_d = 1'b1;
         out_dat_d = core_median;
      end
   end

   // State and datapath registers; reset drops any partial window and any
   // pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         kw_q      <= '0;
         out_dat_q <= '0;
         out_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         kw_q      <= kw_d;
         out_dat_q <= out_dat_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign out_vld = out_vld_q;
   assign out_dat = out_dat_q;

endmodule
